processing_element16: RTL and testbench



---
 rtl/fp16_pkg.sv | 48 ++++
 rtl/fp16_add.sv | 78 +++++++
 rtl/processing_element16.sv | 70 +++++++
 tb/tb_processing_element16.sv | 107 ++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg
//   Shared IEEE 754 binary16 definitions for the processing-element datapath:
//   field widths, bias and special encodings, a packed field view of a
//   16-bit word, and small classification helpers.
//   Configuration macro: PE16_SATURATE_EN selects the overflow encoding
//   returned by fp16_overflow (defined: +/-max finite, undefined: +/-Inf).
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_MAX      = 16'h7BFF;

  // Field view; casting a 16-bit word to this type extracts the fields.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  function automatic logic fp16_is_nan(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    return (e == 5'd31) && (m != '0);
  endfunction

  function automatic logic fp16_is_inf(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    return (e == 5'd31) && (m == '0);
  endfunction

  // Subnormals are treated as zero, so only the exponent matters.
  function automatic logic fp16_is_zero(input logic [EXP_W-1:0] e);
    return (e == '0);
  endfunction

  // Encoding used when a finite computation exceeds the largest exponent.
  function automatic logic [15:0] fp16_overflow(input logic s);
`ifdef PE16_SATURATE_EN
    return {s, FP16_MAX[14:0]};
`else
    return {s, FP16_POS_INF[14:0]};
`endif
  endfunction

endpackage

// File: rtl/fp16_add.sv
// fp16_add
//   Combinational binary16 adder, round toward zero, flush-to-zero.
//   Ports:
//     i_a, i_b : 16-bit FP16 addends
//     o_sum    : 16-bit FP16 sum
//   Overflow encoding follows PE16_SATURATE_EN via fp16_pkg::fp16_overflow.
module fp16_add
  import fp16_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  fp16_t       w_a, w_b, w_big, w_small;
  logic [10:0] w_sig_big, w_sig_small;
  logic [4:0]  w_exp_diff;
  logic [11:0] w_add;
  logic [10:0] w_sub;
  logic [4:0]  w_lz;
  logic        w_eff_sub;

  assign w_a = i_a;
  assign w_b = i_b;

  always_comb begin
    // Order by magnitude so the aligned operand is always the smaller one
    // and the subtraction never goes negative.
    if ({w_a.exp, w_a.man} >= {w_b.exp, w_b.man}) begin
      w_big   = w_a;
      w_small = w_b;
    end else begin
      w_big   = w_b;
      w_small = w_a;
    end
    w_eff_sub   = w_big.sign ^ w_small.sign;
    w_exp_diff  = w_big.exp - w_small.exp;
    w_sig_big   = {1'b1, w_big.man};
    w_sig_small = {1'b1, w_small.man} >> w_exp_diff;  // shifted-out bits discarded
    w_add       = {1'b0, w_sig_big} + {1'b0, w_sig_small};
    w_sub       = w_sig_big - w_sig_small;

    // Leading-zero count of the difference; the highest set bit wins.
    w_lz = 5'd0;
    for (int i = 0; i < 11; i++) begin
      if (w_sub[i]) w_lz = 5'(10 - i);
    end

    o_sum = FP16_POS_ZERO;
    if (fp16_is_nan(w_a.exp, w_a.man) || fp16_is_nan(w_b.exp, w_b.man) ||
        (fp16_is_inf(w_a.exp, w_a.man) && fp16_is_inf(w_b.exp, w_b.man) &&
         (w_a.sign != w_b.sign))) begin
      o_sum = FP16_QNAN;
    end else if (fp16_is_inf(w_a.exp, w_a.man)) begin
      o_sum = i_a;
    end else if (fp16_is_inf(w_b.exp, w_b.man)) begin
      o_sum = i_b;
    end else if (fp16_is_zero(w_a.exp) && fp16_is_zero(w_b.exp)) begin
      o_sum = {w_a.sign & w_b.sign, 15'b0};
    end else if (fp16_is_zero(w_a.exp)) begin
      o_sum = i_b;
    end else if (fp16_is_zero(w_b.exp)) begin
      o_sum = i_a;
    end else if (!w_eff_sub) begin
      if (w_add[11]) begin
        if (w_big.exp == 5'd30) o_sum = fp16_overflow(w_big.sign);
        else                    o_sum = {w_big.sign, 5'(w_big.exp + 5'd1), w_add[10:1]};
      end else begin
        o_sum = {w_big.sign, w_big.exp, w_add[9:0]};
      end
    end else begin
      if (w_sub == '0)              o_sum = FP16_POS_ZERO;        // exact cancellation
      else if (w_big.exp <= w_lz)   o_sum = {w_big.sign, 15'b0};  // below min normal
      else                          o_sum = {w_big.sign, 5'(w_big.exp - w_lz), 10'(w_sub << w_lz)};
    end
  end

endmodule

// File: rtl/processing_element16.sv
// processing_element16
//   FP16 multiply-accumulate element: every clock result <= result + A*B.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous active-high clear of the accumulator
//     floatA : FP16 operand A
//     floatB : FP16 operand B
//     result : registered FP16 accumulator
//   Configuration macro: PE16_SATURATE_EN (overflow clamps to +/-max finite).
module processing_element16
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  output logic [15:0] result
);

  fp16_t              w_a, w_b;
  logic [11:0]        w_prod_hi;
  logic               w_prod_sign;
  logic signed [7:0]  w_prod_exp;
  logic [9:0]         w_prod_man;
  logic [15:0]        w_prod;
  logic [15:0]        w_sum;
  logic [15:0]        r_acc;

  assign w_a = floatA;
  assign w_b = floatB;

  // Upper 12 bits of the 22-bit significand product; the low 10 bits are
  // always truncated, bit 11 tells whether a 1-bit normalisation is needed.
  assign w_prod_hi = 12'(({11'b0, 1'b1, w_a.man} * {11'b0, 1'b1, w_b.man}) >> 10);

  always_comb begin
    w_prod_sign = w_a.sign ^ w_b.sign;
    w_prod_exp  = 8'(w_a.exp) + 8'(w_b.exp) + 8'(w_prod_hi[11]) - 8'd15;
    w_prod_man  = w_prod_hi[11] ? w_prod_hi[10:1] : w_prod_hi[9:0];
    w_prod      = FP16_POS_ZERO;
    if (fp16_is_nan(w_a.exp, w_a.man) || fp16_is_nan(w_b.exp, w_b.man) ||
        (fp16_is_inf(w_a.exp, w_a.man) && fp16_is_zero(w_b.exp)) ||
        (fp16_is_inf(w_b.exp, w_b.man) && fp16_is_zero(w_a.exp))) begin
      w_prod = FP16_QNAN;
    end else if (fp16_is_inf(w_a.exp, w_a.man) || fp16_is_inf(w_b.exp, w_b.man)) begin
      w_prod = {w_prod_sign, FP16_POS_INF[14:0]};
    end else if (fp16_is_zero(w_a.exp) || fp16_is_zero(w_b.exp) || (w_prod_exp <= 8'sd0)) begin
      w_prod = {w_prod_sign, 15'b0};
    end else if (w_prod_exp >= 8'sd31) begin
      w_prod = fp16_overflow(w_prod_sign);
    end else begin
      w_prod = {w_prod_sign, w_prod_exp[4:0], w_prod_man};
    end
  end

  fp16_add u_add (
    .i_a   (r_acc),
    .i_b   (w_prod),
    .o_sum (w_sum)
  );

  // A NaN accumulator stays NaN through the adder, so stickiness is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_acc <= FP16_POS_ZERO;
    else       r_acc <= w_sum;
  end

  assign result = r_acc;

endmodule

// File: tb/tb_processing_element16.sv
module tb_processing_element16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] floatA;
  logic [15:0] floatB;
  logic [15:0] result;

  int n_checks = 0;
  int n_errors = 0;

  processing_element16 dut (
    .clk    (clk),
    .reset  (reset),
    .floatA (floatA),
    .floatB (floatB),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s result=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s result=%h", tag, got);
    end
  endtask

  // Called at a falling edge: drive operands, let one rising edge pass, check.
  task automatic step(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp, input string tag);
    floatA = a;
    floatB = b;
    @(negedge clk);
    check_eq(tag, result, exp);
  endtask

  // Called at a falling edge: assert reset between edges and check that the
  // clear is visible before the next rising edge, then release.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_eq(tag, result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_ovf, exp_inf_fin, exp_inf_inf;
`ifdef PE16_SATURATE_EN
    exp_ovf     = 16'h7BFF;
    exp_inf_fin = 16'h7BFF;
    exp_inf_inf = 16'hFC00;
`else
    exp_ovf     = 16'h7C00;
    exp_inf_fin = 16'h7C00;
    exp_inf_inf = 16'h7E00;
`endif

    reset  = 1'b1;
    floatA = 16'h4000;
    floatB = 16'h4200;
    @(negedge clk);
    check_eq("rst_hold0", result, 16'h0000);
    @(negedge clk);
    check_eq("rst_hold1", result, 16'h0000);
    reset = 1'b0;

    step(16'h4000, 16'h4200, 16'h4600, "acc1");
    step(16'h4000, 16'h4200, 16'h4A00, "acc2");
    step(16'h4000, 16'h4200, 16'h4C80, "acc3");
    async_reset("async_rst_a");

    step(16'h4000, 16'h4200, 16'h4600, "reacc1");
    step(16'h4000, 16'h4200, 16'h4A00, "reacc2");
    async_reset("async_rst_b");

    step(16'hC000, 16'h4200, 16'hC600, "neg_prod");
    step(16'h4000, 16'h4200, 16'h0000, "cancel");

    step(16'h0001, 16'h4200, 16'h0000, "ftz1");
    step(16'h0001, 16'h4200, 16'h0000, "ftz2");
    step(16'h0001, 16'h4200, 16'h0000, "ftz3");
    step(16'h0400, 16'h0400, 16'h0000, "mul_underflow");
    step(16'h8000, 16'h4200, 16'h0000, "neg_zero_sum");

    step(16'h3C01, 16'h3C01, 16'h3C02, "trunc_mul");
    step(16'hBC00, 16'h3C00, 16'h1800, "norm_sub");
    async_reset("async_rst_c");

    step(16'h7BFF, 16'h7BFF, exp_ovf,     "overflow");
    step(16'h4000, 16'h4200, exp_inf_fin, "inf_plus_fin");
    step(16'hFC00, 16'h3C00, exp_inf_inf, "inf_minus_inf");
    async_reset("async_rst_d");

    step(16'h7C00, 16'h0000, 16'h7E00, "nan_inf_x_0");
    step(16'h4000, 16'h4200, 16'h7E00, "nan_sticky");
    async_reset("nan_rst");
    step(16'h7E01, 16'h3C00, 16'h7E00, "nan_input");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
